load_store_unit: RTL and testbench

- Sits between the core's memory stage and the 32 x 64-bit data RAM (5-bit dword index, combinational read, write on posedge clk).
- Accepts one byte-addressed load or store at a time using RISC-V funct3 sizes.
- Loads: extracts and sign- or zero-extends the addressed field.
- Stores: performs read-modify-write for sub-doubleword sizes.
- Flags misaligned or illegal accesses instead of touching memory.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and the byte-lane mask for each access size.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } lsu_state_t;

   // Byte lanes touched by an access at offset 0; funct3[1:0] encodes the size.
   function automatic logic [7:0] size_mask(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: field extraction/extension for loads, byte merge
// for stores, and the misaligned/illegal check.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 64
)
(
   input  logic [DATA_W-1:0] dword,
   input  logic [2:0]        offset,
   input  logic [2:0]        funct3,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_val,
   output logic [DATA_W-1:0] store_val,
   output logic              bad
);

   logic [DATA_W-1:0] field;
   logic [DATA_W-1:0] wshift;
   logic [DATA_W-1:0] bmask;
   logic [7:0]        lanes;
   logic              misaligned;
   logic              illegal;

   always_comb begin
      field = dword >> {offset, 3'b000};
      case (funct3)
         F3_B:    load_val = {{(DATA_W-8){field[7]}}, field[7:0]};
         F3_H:    load_val = {{(DATA_W-16){field[15]}}, field[15:0]};
         F3_W:    load_val = {{(DATA_W-32){field[31]}}, field[31:0]};
         F3_D:    load_val = field;
         F3_BU:   load_val = {{(DATA_W-8){1'b0}}, field[7:0]};
         F3_HU:   load_val = {{(DATA_W-16){1'b0}}, field[15:0]};
         F3_WU:   load_val = {{(DATA_W-32){1'b0}}, field[31:0]};
         default: load_val = '0;
      endcase
   end

   // Misaligned sizes never reach the merge, so lanes shifted past bit 7 don't matter.
   always_comb begin
      lanes  = size_mask(funct3) << offset;
      wshift = wdata << {offset, 3'b000};
      bmask  = '0;
      for (int i = 0; i < 8; i++) begin
         bmask[8*i +: 8] = {8{lanes[i]}};
      end
      store_val = (dword & ~bmask) | (wshift & bmask);
   end

   always_comb begin
      case (funct3[1:0])
         2'b01:   misaligned = offset[0];
         2'b10:   misaligned = |offset[1:0];
         2'b11:   misaligned = |offset;
         default: misaligned = 1'b0;
      endcase
      illegal = we ? funct3[2] : (funct3 == 3'b111);
      bad     = misaligned | illegal;
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the memory stage and a 32 x 64-bit RAM with
// combinational read; stores are read-modify-write.
//
//   state | meaning
//   IDLE  | ready, latch request on accept
//   LOAD  | register extended load field
//   MERGE | register merged store dword
//   WRITE | mem_we high, RAM captures merged dword
//   RESP  | one-cycle response pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64,
   parameter int IDX_W  = 5
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [IDX_W-1:0]  mem_endereco,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut
);

   lsu_state_t        state, state_nxt;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [2:0]        off_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept;
   logic              cur_we;
   logic [2:0]        cur_funct3;
   logic [2:0]        cur_off;
   logic [DATA_W-1:0] cur_wdata;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] store_val;
   logic              bad;

   assign req_ready  = (state == ST_IDLE);
   assign accept     = req_valid & req_ready;
   assign mem_we     = (state == ST_WRITE);
   assign resp_valid = (state == ST_RESP);

   // Legality is judged on the live request in IDLE, on latched fields afterwards.
   assign cur_we     = req_ready ? req_we         : we_q;
   assign cur_funct3 = req_ready ? req_funct3     : funct3_q;
   assign cur_off    = req_ready ? req_addr[2:0]  : off_q;
   assign cur_wdata  = req_ready ? req_wdata      : wdata_q;

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .dword     (mem_dataOut),
      .offset    (cur_off),
      .funct3    (cur_funct3),
      .we        (cur_we),
      .wdata     (cur_wdata),
      .load_val  (load_val),
      .store_val (store_val),
      .bad       (bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (bad)         state_nxt = ST_RESP;
               else if (req_we) state_nxt = ST_MERGE;
               else             state_nxt = ST_LOAD;
            end
         end
         ST_LOAD:  state_nxt = ST_RESP;
         ST_MERGE: state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q         <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         wdata_q      <= '0;
         mem_endereco <= '0;
         mem_dataIn   <= '0;
         resp_rdata   <= '0;
         resp_err     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q         <= req_we;
                  funct3_q     <= req_funct3;
                  off_q        <= req_addr[2:0];
                  wdata_q      <= req_wdata;
                  mem_endereco <= req_addr[ADDR_W-1:3];
                  resp_err     <= bad;
                  resp_rdata   <= '0;
               end
            end
            ST_LOAD:  resp_rdata <= load_val;
            ST_MERGE: mem_dataIn <= store_val;
            ST_RESP:  resp_err   <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// traffic against a byte-level reference memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [7:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_err;
   logic [63:0] resp_rdata;
   logic [4:0]  mem_endereco;
   logic        mem_we;
   logic [63:0] mem_dataIn;
   logic [63:0] mem_dataOut;

   logic [63:0] mem     [32];
   logic [63:0] ref_mem [32];
   logic        init_mem = 1'b1;

   int checks = 0;
   int errors = 0;

   int rdy_pat [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
   int rv_pat  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_endereco (mem_endereco),
      .mem_we       (mem_we),
      .mem_dataIn   (mem_dataIn),
      .mem_dataOut  (mem_dataOut)
   );

   always #5 clk = ~clk;

   assign mem_dataOut = mem[mem_endereco];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 64'd5 : 64'(i + 3);
      end else if (mem_we) begin
         mem[mem_endereco] <= mem_dataIn;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: access = nb bytes starting at byte addr, little-endian.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                 input logic [63:0] wdata, output logic err, output logic [63:0] rdata);
      int nb;
      int idx;
      int off;
      nb    = 1 << f3[1:0];
      idx   = int'(addr[7:3]);
      off   = int'(addr[2:0]);
      err   = (we ? f3[2] : (f3 == 3'b111)) || ((int'(addr) % nb) != 0);
      rdata = '0;
      if (err) return;
      for (int b = 0; b < nb; b++) begin
         if (we) ref_mem[idx][8*(off+b) +: 8] = wdata[8*b +: 8];
         else    rdata[8*b +: 8] = ref_mem[idx][8*(off+b) +: 8];
      end
      if (we) rdata = '0;
      else if (!f3[2] && nb < 8 && rdata[8*nb-1]) begin
         for (int b = nb; b < 8; b++) rdata[8*b +: 8] = 8'hFF;
      end
   endfunction

   task automatic ram_check(input string tag);
      int diff;
      diff = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) diff++;
      check(tag, 64'(diff), 64'd0);
   endtask

   task automatic do_req(input string tag, input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [63:0] wdata, output logic [63:0] rd_obs);
      logic        exp_err;
      logic [63:0] exp_rd;
      int          exp_lat;
      int          lat;
      int          n;
      model(we, f3, addr, wdata, exp_err, exp_rd);
      exp_lat = exp_err ? 1 : (we ? 3 : 2);
      rd_obs  = 'x;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = 8'($urandom_range(0, 255));
      req_wdata  = {$urandom(), $urandom()};
      lat = 0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         @(negedge clk);
         check({tag, "_memwe"}, 64'(mem_we), 64'(!exp_err && we && k == 2));
         if (resp_valid) begin
            lat = k;
            check({tag, "_err"}, 64'(resp_err), 64'(exp_err));
            check({tag, "_rdata"}, resp_rdata, exp_rd);
            rd_obs = resp_rdata;
         end else begin
            check({tag, "_busy"}, 64'(req_ready), 64'd0);
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(resp_valid), 64'd0);
      check({tag, "_idle"}, 64'(req_ready), 64'd1);
      ram_check({tag, "_ram"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic        e;
      for (int i = 0; i < 32; i++) ref_mem[i] = (i == 0) ? 64'd5 : 64'(i + 3);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(resp_valid), 64'd0);
      check("rst_err", 64'(resp_err), 64'd0);
      check("rst_rdata", resp_rdata, 64'd0);
      check("rst_memwe", 64'(mem_we), 64'd0);
      check("rst_idx", 64'(mem_endereco), 64'd0);
      check("rst_din", mem_dataIn, 64'd0);
      check("rst_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
      init_mem = 1'b0;
      rst_n    = 1'b1;

      do_req("ld08", 1'b0, 3'b011, 8'h08, 64'd0, rd);
      check("ld08_val", rd, 64'h0000000000000004);
      do_req("sb11", 1'b1, 3'b000, 8'h11, 64'h80, rd);
      check("sb11_mem", mem[2], 64'h0000000000008005);
      do_req("lb11", 1'b0, 3'b000, 8'h11, 64'd0, rd);
      check("lb11_val", rd, 64'hFFFFFFFFFFFFFF80);
      do_req("lbu11", 1'b0, 3'b100, 8'h11, 64'd0, rd);
      check("lbu11_val", rd, 64'h0000000000000080);
      do_req("sw1c", 1'b1, 3'b010, 8'h1C, 64'hDEADBEEF, rd);
      check("sw1c_mem", mem[3], 64'hDEADBEEF00000006);
      do_req("lw1c", 1'b0, 3'b010, 8'h1C, 64'd0, rd);
      check("lw1c_val", rd, 64'hFFFFFFFFDEADBEEF);
      do_req("lwu1c", 1'b0, 3'b110, 8'h1C, 64'd0, rd);
      check("lwu1c_val", rd, 64'h00000000DEADBEEF);

      do_req("err_lw02", 1'b0, 3'b010, 8'h02, 64'd0, rd);
      do_req("err_sd0c", 1'b1, 3'b011, 8'h0C, 64'h5555, rd);
      do_req("err_ld111", 1'b0, 3'b111, 8'h10, 64'd0, rd);
      do_req("err_sbu", 1'b1, 3'b100, 8'h30, 64'hAA, rd);

      // Reset pulse while the store sits in WRITE: no write, no response.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b011;
      req_addr   = 8'h20;
      req_wdata  = 64'h1234;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_memwe_pre", 64'(mem_we), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_memwe", 64'(mem_we), 64'd0);
      check("midrst_valid", 64'(resp_valid), 64'd0);
      check("midrst_err", 64'(resp_err), 64'd0);
      check("midrst_rdata", resp_rdata, 64'd0);
      check("midrst_idx", 64'(mem_endereco), 64'd0);
      check("midrst_din", mem_dataIn, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_mem4", mem[4], 64'd7);
      check("midrst_ready", 64'(req_ready), 64'd1);
      check("midrst_noresp", 64'(resp_valid), 64'd0);
      ram_check("midrst_ram");

      // Back-to-back stores with req_valid held high.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 8'h28;
      req_wdata  = 64'hCAFEF00D;
      model(1'b1, 3'b010, 8'h28, 64'hCAFEF00D, e, rd);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("b2b_ready%0d", k), 64'(req_ready), 64'(rdy_pat[k]));
         check($sformatf("b2b_resp%0d", k), 64'(resp_valid), 64'(rv_pat[k]));
         if (k == 7) req_valid = 1'b0;
      end
      @(negedge clk);
      check("b2b_tail", 64'(resp_valid), 64'd0);
      ram_check("b2b_ram");
      check("b2b_mem5", mem[5], 64'h00000000CAFEF00D);

      for (int i = 0; i < 40; i++) begin
         logic       we;
         logic [2:0] f3;
         logic [7:0] a;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~8'((1 << f3[1:0]) - 1);
         do_req($sformatf("rnd%0d", i), we, f3, a, {$urandom(), $urandom()}, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
